// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the Lab4 multi-cycle sequencer and its decode stage.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;

  // R-type function codes (instr[5:0]) under OP_OTHER0
  localparam logic [5:0] OP0_ADD = 6'h20;
  localparam logic [5:0] OP0_SUB = 6'h22;
  localparam logic [5:0] OP0_AND = 6'h24;
  localparam logic [5:0] OP0_OR  = 6'h25;
  localparam logic [5:0] OP0_XOR = 6'h26;
  localparam logic [5:0] OP0_NOR = 6'h27;

  // ALU control
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_NOR = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  // Second ALU operand select
  localparam logic [1:0] SRC2_REG  = 2'b00;
  localparam logic [1:0] SRC2_SEXT = 2'b01;
  localparam logic [1:0] SRC2_ZEXT = 2'b10;
  localparam logic [1:0] SRC2_NONE = 2'b11;

endpackage

// File: rtl/mips_decode.sv
// Combinational opcode/funct decoder; anything not listed raises o_except.
module mips_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_alu_src2,
  output logic       o_rd_src,
  output logic       o_except
);

  // Map opcode/funct to ALU controls; default is an unrecognized instruction
  always_comb begin
    o_alu_op   = ALU_ADD;
    o_alu_src2 = SRC2_NONE;
    o_rd_src   = 1'b0;
    o_except   = 1'b1;
    case (i_opcode)
      OP_OTHER0: begin
        o_alu_src2 = SRC2_REG;
        o_rd_src   = 1'b0;
        o_except   = 1'b0;
        case (i_funct)
          OP0_ADD: o_alu_op = ALU_ADD;
          OP0_SUB: o_alu_op = ALU_SUB;
          OP0_AND: o_alu_op = ALU_AND;
          OP0_OR:  o_alu_op = ALU_OR;
          OP0_XOR: o_alu_op = ALU_XOR;
          OP0_NOR: o_alu_op = ALU_NOR;
          default: o_except = 1'b1;
        endcase
      end
      OP_ADDI: begin
        o_alu_op   = ALU_ADD;
        o_alu_src2 = SRC2_SEXT;
        o_rd_src   = 1'b1;
        o_except   = 1'b0;
      end
      OP_ANDI: begin
        o_alu_op   = ALU_AND;
        o_alu_src2 = SRC2_ZEXT;
        o_rd_src   = 1'b1;
        o_except   = 1'b0;
      end
      OP_ORI: begin
        o_alu_op   = ALU_OR;
        o_alu_src2 = SRC2_ZEXT;
        o_rd_src   = 1'b1;
        o_except   = 1'b0;
      end
      OP_XORI: begin
        o_alu_op   = ALU_XOR;
        o_alu_src2 = SRC2_ZEXT;
        o_rd_src   = 1'b1;
        o_except   = 1'b0;
      end
      default: o_except = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the Lab4 datapath.
// Define INSTR_COUNT_EN to implement the retired-instruction counter; otherwise
// instr_count is tied to zero.
module mips_seq_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic               clear_except,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [31:0]        instr,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic               rd_src,
  output logic [1:0]         alu_src2,
  output logic [2:0]         alu_op,
  output logic               except,
  output logic               busy,
  output logic [COUNT_W-1:0] instr_count
);

  state_e     r_state, w_state_d;
  logic [5:0] r_opcode, r_funct;
  logic       r_except, r_rd_src;
  logic [1:0] r_alu_src2;
  logic [2:0] r_alu_op;

  logic [2:0] w_dec_alu_op;
  logic [1:0] w_dec_alu_src2;
  logic       w_dec_rd_src, w_dec_except;
  logic       w_fetch_done;
  logic       w_unused_instr;

  // Operand/immediate fields are consumed by the datapath, not here
  assign w_unused_instr = ^instr[25:6];

  assign w_fetch_done = (r_state == StFetch) && imem_ack;

  mips_decode u_decode (
    .i_opcode   (r_opcode),
    .i_funct    (r_funct),
    .o_alu_op   (w_dec_alu_op),
    .o_alu_src2 (w_dec_alu_src2),
    .o_rd_src   (w_dec_rd_src),
    .o_except   (w_dec_except)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (run) w_state_d = StFetch;
      StFetch:  if (imem_ack) w_state_d = StDecode;
      StDecode: w_state_d = w_dec_except ? StHalt : StExec;
      StExec:   w_state_d = StWb;
      StWb:     w_state_d = run ? StFetch : StIdle;
      StHalt:   if (clear_except) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // IR field latch on accepted fetch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_opcode <= '0;
      r_funct  <= '0;
    end else if (w_fetch_done) begin
      r_opcode <= instr[31:26];
      r_funct  <= instr[5:0];
    end
  end

  // Decoded controls captured in DECODE; a faulting decode leaves them untouched
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_src   <= 1'b0;
      r_alu_src2 <= 2'b00;
      r_alu_op   <= 3'b000;
    end else if ((r_state == StDecode) && !w_dec_except) begin
      r_rd_src   <= w_dec_rd_src;
      r_alu_src2 <= w_dec_alu_src2;
      r_alu_op   <= w_dec_alu_op;
    end
  end

  // Sticky exception: set leaving DECODE, cleared only from HALT
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_except <= 1'b0;
    end else if ((r_state == StDecode) && w_dec_except) begin
      r_except <= 1'b1;
    end else if ((r_state == StHalt) && clear_except) begin
      r_except <= 1'b0;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [COUNT_W-1:0] r_count;

  // Retire counter, bumps on the edge leaving WB and wraps naturally
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              r_count <= '0;
    else if (r_state == StWb)  r_count <= r_count + COUNT_W'(1);
  end

  assign instr_count = r_count;
`else
  assign instr_count = '0;
`endif

  assign imem_req  = (r_state == StFetch);
  assign ir_write  = imem_req & imem_ack;
  assign reg_write = (r_state == StWb);
  assign pc_write  = (r_state == StWb);
  assign busy      = (r_state != StIdle) && (r_state != StHalt);
  assign except    = r_except;
  assign rd_src    = r_rd_src;
  assign alu_src2  = r_alu_src2;
  assign alu_op    = r_alu_op;

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Scoreboard bench for mips_seq_ctrl: the stimulus thread queues expected
// retire/fault results, a negedge monitor pops and checks them as they appear.
module tb_mips_seq_ctrl;

  localparam int CW = 4;

`ifdef INSTR_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n, run, clear_except, imem_ack;
  logic [31:0]   instr;
  logic          imem_req, ir_write, pc_write, reg_write, rd_src, except, busy;
  logic [1:0]    alu_src2;
  logic [2:0]    alu_op;
  logic [CW-1:0] instr_count;

  mips_seq_ctrl #(.COUNT_W(CW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .run          (run),
    .clear_except (clear_except),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .instr        (instr),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .rd_src       (rd_src),
    .alu_src2     (alu_src2),
    .alu_op       (alu_op),
    .except       (except),
    .busy         (busy),
    .instr_count  (instr_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          is_exc;
    logic [2:0]    op;
    logic [1:0]    src2;
    logic          rd;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [CW-1:0] m_count = '0;

  // Directed vectors: word, alu_op, alu_src2, rd_src
  logic [31:0] t_w   [8] = '{32'h00851022, 32'h00851024, 32'h00851025, 32'h00851027,
                             32'h00851026, 32'h20A40005, 32'h30A40001, 32'h34A4000F};
  logic [2:0]  t_op  [8] = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b100, 3'b101};
  logic [1:0]  t_s2  [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10};
  logic        t_rd  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic exc, input logic [2:0] op, input logic [1:0] s2,
                      input logic rd);
    exp_t e;
    e.is_exc = exc;
    e.op     = op;
    e.src2   = s2;
    e.rd     = rd;
    e.cnt    = CntEn ? m_count : CW'(0);
    sb.push_back(e);
    if (!exc) m_count = m_count + CW'(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_imem_req"},  32'(imem_req),    32'd0);
    chk({tag, "_ir_write"},  32'(ir_write),    32'd0);
    chk({tag, "_pc_write"},  32'(pc_write),    32'd0);
    chk({tag, "_reg_write"}, 32'(reg_write),   32'd0);
    chk({tag, "_rd_src"},    32'(rd_src),      32'd0);
    chk({tag, "_alu_src2"},  32'(alu_src2),    32'd0);
    chk({tag, "_alu_op"},    32'(alu_op),      32'd0);
    chk({tag, "_except"},    32'(except),      32'd0);
    chk({tag, "_busy"},      32'(busy),        32'd0);
    chk({tag, "_count"},     32'(instr_count), 32'd0);
  endtask

  // Wait for FETCH, hold ack off for 'delay' cycles, then present the word.
  // Returns on the negedge after the ack cycle (state DECODE).
  task automatic fetch(input logic [31:0] w, input int delay);
    int k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("fetch_req_seen", 32'(imem_req), 32'd1);
    for (int i = 0; i < delay; i++) begin
      chk("req_wait", 32'(imem_req), 32'd1);
      chk("irw_wait", 32'(ir_write), 32'd0);
      @(negedge clock);
    end
    imem_ack = 1'b1;
    instr    = w;
    #1;
    chk("ir_write", 32'(ir_write), 32'd1);
    @(negedge clock);
    imem_ack = 1'b0;
    instr    = 32'hDEAD_BEEF;
    #1;
    chk("req_drop", 32'(imem_req), 32'd0);
    chk("busy_dec", 32'(busy), 32'd1);
  endtask

  // One legal instruction; ends on the WB negedge. 'last' drops run there.
  task automatic run_instr(input logic [31:0] w, input int delay, input logic [2:0] op,
                           input logic [1:0] s2, input logic rd, input bit last);
    int lat = 1;
    push(1'b0, op, s2, rd);
    fetch(w, delay);
    while (!reg_write && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    chk("wb_latency", 32'(lat), 32'd3);
    if (last) run = 1'b0;
  endtask

  // Monitor: check retirements and fault entries against the scoreboard
  logic prev_except = 1'b0;
  logic prev_rw = 1'b0;
  always @(negedge clock) begin
    exp_t it;
    if (reset_n) begin
      if (reg_write) begin
        chk("rw_single_cycle", 32'(prev_rw), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_reg_write", 32'(reg_write), 32'd0);
        end else begin
          it = sb.pop_front();
          chk("sb_is_legal", 32'(it.is_exc), 32'd0);
          chk("wb_pc_write", 32'(pc_write), 32'd1);
          chk("wb_alu_op",   32'(alu_op),   32'(it.op));
          chk("wb_alu_src2", 32'(alu_src2), 32'(it.src2));
          chk("wb_rd_src",   32'(rd_src),   32'(it.rd));
          chk("wb_count",    32'(instr_count), 32'(it.cnt));
        end
      end
      if (except && !prev_except) begin
        if (sb.size() == 0) begin
          chk("unexpected_except", 32'(except), 32'd0);
        end else begin
          it = sb.pop_front();
          chk("sb_is_exc",     32'(it.is_exc),   32'd1);
          chk("exc_reg_write", 32'(reg_write),   32'd0);
          chk("exc_pc_write",  32'(pc_write),    32'd0);
          chk("exc_busy",      32'(busy),        32'd0);
          chk("exc_count",     32'(instr_count), 32'(it.cnt));
        end
      end
    end
    prev_except <= except;
    prev_rw     <= reg_write;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    run          = 1'b1;
    clear_except = 1'b0;
    imem_ack     = 1'b0;
    instr        = 32'h0;
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);
    chk("req_after_reset", 32'(imem_req), 32'd1);

    // add, same-cycle ack
    run_instr(32'h00851020, 0, 3'b010, 2'b00, 1'b0, 1'b0);
    @(negedge clock);
    chk("count_after_add", 32'(instr_count), CntEn ? 32'd1 : 32'd0);
    chk("b2b_req_add", 32'(imem_req), 32'd1);

    // xori with 3 wait cycles; a stray clear_except outside HALT is harmless
    clear_except = 1'b1;
    run_instr(32'h38A4FFFF, 3, 3'b111, 2'b10, 1'b1, 1'b0);
    clear_except = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("b2b_req", 32'(imem_req), 32'd1);
      run_instr(t_w[i], 0, t_op[i], t_s2[i], t_rd[i], i == 7);
    end
    @(negedge clock);
    chk("idle_req", 32'(imem_req), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    imem_ack = 1'b1;
    @(negedge clock);
    imem_ack = 1'b0;
    chk("ack_in_idle_req", 32'(imem_req), 32'd0);
    chk("ack_in_idle_busy", 32'(busy), 32'd0);

    // Illegal opcode 0x3F
    push(1'b1, 3'b000, 2'b00, 1'b0);
    run = 1'b1;
    fetch(32'hFC000000, 0);
    for (int k = 0; k < 5 && !except; k++) @(negedge clock);
    chk("halt_except", 32'(except), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_alu_op_held", 32'(alu_op), 32'd5);
    chk("halt_src2_held", 32'(alu_src2), 32'd2);
    repeat (2) @(negedge clock);
    chk("halt_sticky", 32'(except), 32'd1);
    chk("halt_no_fetch", 32'(imem_req), 32'd0);
    run          = 1'b0;
    clear_except = 1'b1;
    @(negedge clock);
    clear_except = 1'b0;
    chk("cleared_except", 32'(except), 32'd0);
    chk("cleared_busy", 32'(busy), 32'd0);
    chk("cleared_count", 32'(instr_count), CntEn ? 32'(m_count) : 32'd0);
    @(negedge clock);
    chk("cleared_idle_req", 32'(imem_req), 32'd0);

    // run falls during EXEC: instruction still retires, then IDLE
    push(1'b0, 3'b010, 2'b00, 1'b0);
    run = 1'b1;
    fetch(32'h00851020, 0);
    @(negedge clock);
    run = 1'b0;
    @(negedge clock);
    chk("rundrop_wb", 32'(reg_write), 32'd1);
    repeat (3) begin
      @(negedge clock);
      chk("rundrop_no_req", 32'(imem_req), 32'd0);
    end

    // Reset during EXEC: dropped, outputs cleared asynchronously
    run = 1'b1;
    fetch(32'h00851020, 0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    m_count = '0;
    @(negedge clock);
    chk("rst_no_rw", 32'(reg_write), 32'd0);
    reset_n = 1'b1;

    // 2^CW + 1 back-to-back adds wrap the counter to 1
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      @(negedge clock);
      chk("wrap_b2b_req", 32'(imem_req), 32'd1);
      run_instr(32'h00851020, 0, 3'b010, 2'b00, 1'b0, i == (1 << CW));
    end
    @(negedge clock);
    chk("wrap_count", 32'(instr_count), CntEn ? 32'd1 : 32'd0);
    chk("wrap_idle", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
